// File: rtl/arb_pkg.sv
// Shared types and helpers for the per-slave crossbar arbiter.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: FSM state encoding, clog2 helper, default watchdog limit.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEF = 1023;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/slave_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last owner.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the pick.
// Ports: i_req (requests), i_last (previous owner), o_onehot/o_idx (winner),
//        o_any (at least one request present).
module rr_pick #(
  parameter int NM   = 4,
  parameter int LGNM = 2
) (
  input  logic [NM-1:0]   i_req,
  input  logic [LGNM-1:0] i_last,
  output logic [NM-1:0]   o_onehot,
  output logic [LGNM-1:0] o_idx,
  output logic            o_any
);

  always_comb begin
    int v_pos;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    v_pos    = 0;
    // Walk last+1 .. last+NM with explicit wrap so non power-of-two NM works.
    for (int k = 1; k <= NM; k++) begin
      v_pos = int'(i_last) + k;
      if (v_pos >= NM) v_pos = v_pos - NM;
      if (!o_any && i_req[LGNM'(v_pos)]) begin
        o_any                   = 1'b1;
        o_onehot[LGNM'(v_pos)]  = 1'b1;
        o_idx                   = LGNM'(v_pos);
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Shares one decoded slave port between NM masters; round-robin grant held
// for the whole bus cycle including drain of outstanding acks.
// Latency: 1 cycle request->grant; strobe/stall/ack routing is combinational.
// Backpressure: non-owners always stalled; owner stalled by slave stall or
// when the outstanding counter is full.
// Optional feature macro: ARB_TIMEOUT_EN (ack watchdog with abort pulse).
// Ports: i_clk/i_reset_n; i_req/i_stb per master; i_slv_stall/ack/err from
// slave; o_grant/o_owner/o_busy state; o_slv_stb to slave; o_mstall/o_mack/
// o_merr per master; o_timeout_err one-cycle abort pulse.
module slave_port_arbiter
  import arb_pkg::*;
#(
  parameter int NM       = 4,
  parameter int LGNM     = 2,
  parameter int LGMAXOUT = 4,
  parameter int TIMEOUT  = ARB_TIMEOUT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [NM-1:0]   i_req,
  input  logic [NM-1:0]   i_stb,
  input  logic            i_slv_stall,
  input  logic            i_slv_ack,
  input  logic            i_slv_err,
  output logic [NM-1:0]   o_grant,
  output logic [LGNM-1:0] o_owner,
  output logic            o_slv_stb,
  output logic [NM-1:0]   o_mstall,
  output logic [NM-1:0]   o_mack,
  output logic [NM-1:0]   o_merr,
  output logic            o_busy,
  output logic            o_timeout_err
);

  arb_state_t            r_state;
  logic [NM-1:0]         r_grant;
  logic [LGNM-1:0]       r_owner;
  logic [LGNM-1:0]       r_last;
  logic [LGMAXOUT-1:0]   r_count;
  logic [LGMAXOUT-1:0]   w_count_nxt;

  logic [NM-1:0]         w_pick_oh;
  logic [LGNM-1:0]       w_pick_idx;
  logic                  w_pick_any;
  logic                  w_full;
  logic                  w_cnt_zero;
  logic                  w_own_req;
  logic                  w_take;
  logic                  w_ret;
  logic                  w_timeout;

  rr_pick #(.NM(NM), .LGNM(LGNM)) u_pick (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_full     = (r_count == {LGMAXOUT{1'b1}});
  assign w_cnt_zero = (r_count == '0);
  assign w_own_req  = i_req[r_owner];

  // Strobe is also gated by the owner's request: a master that has dropped
  // its cycle must not launch anything while we decide between IDLE/DRAIN.
  assign o_slv_stb = (r_state == GRANT) && w_own_req && i_stb[r_owner] && !w_full;
  assign w_take    = o_slv_stb && !i_slv_stall;
  // Returns with nothing outstanding are stray and ignored entirely.
  assign w_ret     = (i_slv_ack || i_slv_err) && !w_cnt_zero;

  always_comb begin
    w_count_nxt = r_count;
    if (w_take && !w_ret)      w_count_nxt = r_count + 1'b1;
    else if (!w_take && w_ret) w_count_nxt = r_count - 1'b1;
  end

  always_comb begin
    o_mstall = '0;
    o_mack   = '0;
    o_merr   = '0;
    if (r_state == GRANT) begin
      o_mstall          = '1;
      o_mstall[r_owner] = i_slv_stall || w_full;
      if (!w_cnt_zero) begin
        o_mack[r_owner] = i_slv_ack;
        o_merr[r_owner] = i_slv_err || w_timeout;
      end
    end else if (r_state == DRAIN) begin
      // Owner already ended its cycle: hold everyone off, swallow returns.
      o_mstall = '1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int LGTO = clog2(TIMEOUT + 1);
  logic [LGTO-1:0] r_wd;
  logic            w_wd_run;

  // Watchdog runs only while something is outstanding and the slave is silent.
  assign w_wd_run  = (r_state != IDLE) && !w_cnt_zero && !(i_slv_ack || i_slv_err);
  assign w_timeout = w_wd_run && (r_wd == LGTO'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                r_wd <= '0;
    else if (!w_wd_run || w_timeout) r_wd <= '0;
    else                           r_wd <= r_wd + 1'b1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  assign o_timeout_err = w_timeout;
  assign o_grant       = r_grant;
  assign o_owner       = r_owner;
  assign o_busy        = (r_state != IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= LGNM'(NM - 1);   // so master 0 wins the first arbitration
      r_count <= '0;
    end else begin
      r_count <= w_timeout ? '0 : w_count_nxt;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state <= GRANT;
            r_grant <= w_pick_oh;
            r_owner <= w_pick_idx;
            r_last  <= w_pick_idx;
          end
        end
        GRANT: begin
          if (w_timeout || (!w_own_req && w_cnt_zero)) begin
            r_state <= IDLE;
            r_grant <= '0;
          end else if (!w_own_req) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as soon as the last ack lands, same cycle included.
          if (w_timeout || (w_count_nxt == '0)) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Self-checking bench for slave_port_arbiter (NM=4, LGMAXOUT=2, TIMEOUT=8).
// A cycle-level reference model tracks owner, outstanding count and silence
// length; every negedge compares all outputs, directed steps pin key values.
module tb_slave_port_arbiter;

  localparam int NM       = 4;
  localparam int LGNM     = 2;
  localparam int LGMAXOUT = 2;
  localparam int TIMEOUT  = 8;
  localparam int MAXOUT   = (1 << LGMAXOUT) - 1;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NM-1:0]   req = '0;
  logic [NM-1:0]   stb = '0;
  logic            stall = 1'b0;
  logic            ack = 1'b0;
  logic            err = 1'b0;
  logic [NM-1:0]   o_grant;
  logic [LGNM-1:0] o_owner;
  logic            o_slv_stb;
  logic [NM-1:0]   o_mstall;
  logic [NM-1:0]   o_mack;
  logic [NM-1:0]   o_merr;
  logic            o_busy;
  logic            o_timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  slave_port_arbiter #(
    .NM(NM), .LGNM(LGNM), .LGMAXOUT(LGMAXOUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_req         (req),
    .i_stb         (stb),
    .i_slv_stall   (stall),
    .i_slv_ack     (ack),
    .i_slv_err     (err),
    .o_grant       (o_grant),
    .o_owner       (o_owner),
    .o_slv_stb     (o_slv_stb),
    .o_mstall      (o_mstall),
    .o_mack        (o_mack),
    .o_merr        (o_merr),
    .o_busy        (o_busy),
    .o_timeout_err (o_timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 owned, 2 draining.
  int m_phase = 0;
  int m_owner = 0;
  int m_last  = NM - 1;
  int m_cnt   = 0;
  int m_quiet = 0;

  logic [NM-1:0] e_grant, e_mstall, e_mack, e_merr;
  logic          e_stb, e_busy, e_to, e_silent;
  int            e_delta;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic eval_model();
    bit full, owned, ret;
    owned    = (m_phase == 1);
    full     = (m_cnt == MAXOUT);
    e_busy   = (m_phase != 0);
    e_grant  = e_busy ? NM'(1 << m_owner) : '0;
    e_stb    = owned && req[m_owner] && stb[m_owner] && !full;
    e_mstall = e_busy ? '1 : '0;
    if (owned) e_mstall[m_owner] = stall || full;
    e_silent = e_busy && (m_cnt != 0) && !(ack || err);
    e_to     = TO_EN && e_silent && (m_quiet + 1 == TIMEOUT);
    e_mack   = '0;
    e_merr   = '0;
    if (owned && m_cnt != 0) begin
      e_mack[m_owner] = ack;
      e_merr[m_owner] = err || e_to;
    end
    ret     = (ack || err) && (m_cnt != 0);
    e_delta = int'(e_stb && !stall) - int'(ret);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_last = NM - 1; m_cnt = 0; m_quiet = 0;
    end else begin
      int new_cnt;
      eval_model();
      new_cnt = e_to ? 0 : m_cnt + e_delta;
      m_quiet = (e_silent && !e_to) ? m_quiet + 1 : 0;
      case (m_phase)
        0: begin
          for (int k = 1; k <= NM; k++) begin
            int c;
            c = (m_last + k) % NM;
            if (m_phase == 0 && req[c]) begin
              m_phase = 1; m_owner = c; m_last = c;
            end
          end
        end
        1: begin
          if (e_to) m_phase = 0;
          else if (!req[m_owner]) m_phase = (m_cnt == 0) ? 0 : 2;
        end
        default: if (e_to || new_cnt == 0) m_phase = 0;
      endcase
      m_cnt = new_cnt;
    end
  end

  always @(negedge clk) begin
    eval_model();
    chk("grant", o_grant, e_grant);
    chk("busy", o_busy, e_busy);
    if (e_busy) chk("owner", o_owner, m_owner);
    chk("slv_stb", o_slv_stb, e_stb);
    chk("mstall", o_mstall, e_mstall);
    chk("mack", o_mack, e_mack);
    chk("merr", o_merr, e_merr);
    chk("timeout_err", o_timeout_err, e_to);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  initial begin
    // 1: reset values, first grant to master 0, latency 1
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    probe();
    chk("t1_rst_grant", o_grant, 4'b0000);
    chk("t1_rst_owner", o_owner, 2'd0);
    chk("t1_rst_busy", o_busy, 1'b0);
    chk("t1_rst_to", o_timeout_err, 1'b0);
    nxt(); req = 4'b0101;
    probe(); chk("t1_lat_grant", o_grant, 4'b0000);
    nxt();
    probe(); chk("t1_grant", o_grant, 4'b0001);
    chk("t1_mstall2", o_mstall[2], 1'b1);

    // 2: round robin with an idle gap
    nxt(); req = 4'b0100;
    probe(); chk("t2_hold", o_grant, 4'b0001);
    nxt(); req = 4'b0101;
    probe(); chk("t2_idle_gap", o_busy, 1'b0);
    nxt();
    probe(); chk("t2_grant2", o_grant, 4'b0100);
    chk("t2_owner2", o_owner, 2'd2);
    nxt(); req = 4'b0001;
    nxt(); req = 4'b0101;
    probe(); chk("t2_idle_gap2", o_grant, 4'b0000);
    nxt();
    probe(); chk("t2_grant0", o_grant, 4'b0001);

    // 3: three strobes, drop at count 3, drain swallows acks
    nxt(); stb = 4'b0001;
    probe(); chk("t3_stb1", o_slv_stb, 1'b1);
    chk("t3_mstall", o_mstall, 4'b1110);
    nxt(); probe(); chk("t3_stb2", o_slv_stb, 1'b1);
    nxt(); probe(); chk("t3_stb3", o_slv_stb, 1'b1);
    nxt(); stb = 4'b0000; req = 4'b0100;
    nxt(); ack = 1'b1;
    probe(); chk("t3_drain_mstall", o_mstall, 4'b1111);
    chk("t3_drain_mack", o_mack, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      nxt(); probe();
      chk("t3_drain_busy", o_busy, 1'b1);
      chk("t3_drain_mack", o_mack, 4'b0000);
    end
    nxt(); ack = 1'b0; req = 4'b0000;
    probe(); chk("t3_idle", o_busy, 1'b0);

    // 4: full counter blocks strobes; ack+strobe keeps count
    nxt(); req = 4'b0010;
    nxt(); stb = 4'b0010;
    probe(); chk("t4_grant1", o_grant, 4'b0010);
    nxt(); stall = 1'b1;
    probe(); chk("t4_stall_pass", o_mstall, 4'b1111);
    nxt(); stall = 1'b0;
    nxt(); nxt();
    probe(); chk("t4_full_stb", o_slv_stb, 1'b0);
    chk("t4_full_mstall1", o_mstall[1], 1'b1);
    nxt(); ack = 1'b1;
    probe(); chk("t4_ack_full", o_mack, 4'b0010);
    chk("t4_ack_full_stb", o_slv_stb, 1'b0);
    nxt();
    probe(); chk("t4_ack_stb", o_slv_stb, 1'b1);
    nxt(); ack = 1'b0;
    probe(); chk("t4_refill", o_slv_stb, 1'b1);
    nxt();
    probe(); chk("t4_full_again", o_slv_stb, 1'b0);
    nxt(); stb = 4'b0000; ack = 1'b1;
    nxt(); nxt();
    nxt();
    probe(); chk("t4_stray_ack", o_mack, 4'b0000);
    nxt(); ack = 1'b0; req = 4'b0000;
    nxt();

    // 5: stray ack in idle, async reset mid-grant
    nxt(); ack = 1'b1;
    probe(); chk("t5_idle_ack", o_mack, 4'b0000);
    nxt(); ack = 1'b0; req = 4'b0001;
    nxt(); stb = 4'b0001;
    probe(); chk("t5_grant0", o_grant, 4'b0001);
    nxt();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", o_grant, 4'b0000);
    chk("t5_rst_busy", o_busy, 1'b0);
    chk("t5_rst_stb", o_slv_stb, 1'b0);
    chk("t5_rst_mstall", o_mstall, 4'b0000);
    chk("t5_rst_owner", o_owner, 2'd0);
    nxt(); stb = 4'b0000; req = 4'b0000;
    nxt(); rst_n = 1'b1;
    nxt();

`ifdef ARB_TIMEOUT_EN
    // 6: watchdog abort after TIMEOUT silent cycles
    nxt(); req = 4'b0001;
    nxt(); stb = 4'b0001;
    probe(); chk("t6_stb", o_slv_stb, 1'b1);
    nxt(); stb = 4'b0000;
    for (int k = 1; k < TIMEOUT; k++) begin
      probe(); chk("t6_no_to", o_timeout_err, 1'b0);
      nxt();
    end
    probe(); chk("t6_to", o_timeout_err, 1'b1);
    chk("t6_merr", o_merr, 4'b0001);
    nxt(); req = 4'b0000; ack = 1'b1;
    probe(); chk("t6_idle", o_busy, 1'b0);
    chk("t6_late_ack", o_mack, 4'b0000);
    nxt(); ack = 1'b0;
`endif

    repeat (2) nxt();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
